// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory and decode-stage handshake bundle for fetch_sequencer
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer (optional FETCH_SEQUENCER_MISALIGN_TRAP_EN)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fetch_sequencer_if.master         bus,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    input  logic                      halt_req,
    output logic                      busy,
    output logic                      misalign
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        kill_q, kill_d;
    logic        misalign_q, misalign_d;

    logic [31:0] redir_target;
    logic        redir_bad;
    logic        stop;

    // Redirect target qualification: trap on misaligned targets, or silently align them
`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
    always_comb begin
        redir_target = redirect_pc;
        redir_bad    = redirect && (redirect_pc[1:0] != 2'b00);
    end
`else
    logic unused_redirect_low;
    always_comb begin
        redir_target        = {redirect_pc[31:2], 2'b00};
        redir_bad           = 1'b0;
        unused_redirect_low = ^redirect_pc[1:0];
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            kill_q       <= kill_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next-state and datapath update; a redirect always retargets pc, the last one wins
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        kill_d       = kill_q;
        misalign_d   = misalign_q | redir_bad;
        stop         = misalign_d | halt_req;

        if (redirect) begin
            pc_d = redir_target;
        end

        case (state_q)
            S_IDLE: begin
                state_d = stop ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (bus.imem_gnt) begin
                    // A redirect racing the grant leaves a stale response in flight
                    state_d = S_RESP;
                    kill_d  = redirect;
                end else if (stop) begin
                    state_d = S_HALT;
                end
            end
            S_RESP: begin
                if (bus.imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = stop ? S_HALT : S_REQ;
                    end else begin
                        inst_d       = bus.imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'(PC_STEP);
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = stop ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                if (!stop) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.imem_req   = (state_q == S_REQ);
        bus.imem_addr  = pc_q;
        bus.inst_valid = inst_valid_q;
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        busy           = (state_q == S_RESP);
        misalign       = misalign_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        busy;
    logic        misalign;
    int          checks;
    int          errors;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .busy        (busy),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Full fetch from REQ with single-cycle grant and response, consumed immediately
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_req_resp", 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        check("fetch_valid", 32'(bus.inst_valid), 32'd1);
        check("fetch_inst", bus.inst, data);
        check("fetch_inst_pc", bus.inst_pc, addr);
        check("fetch_busy_hold", 32'(busy), 32'd0);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("fetch_valid_clr", 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        halt_req        = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;

        // Reset state
        #3;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("idle_req", 32'(bus.imem_req), 32'd0);
        tick();

        // Grant withheld: address stays at the reset pc
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_addr", bus.imem_addr, 32'h0);
            tick();
        end

        // Sequential fetch stream
        fetch(32'h0000_0000, 32'hA000_0000);
        fetch(32'h0000_0004, 32'hA000_0004);
        fetch(32'h0000_0008, 32'hA000_0008);

        // Redirect while waiting on the response: data dropped
        check("resp_redir_addr0", bus.imem_addr, 32'h0000_000C);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("resp_redir_busy", 32'(busy), 32'd1);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        check("resp_redir_valid", 32'(bus.inst_valid), 32'd0);
        check("resp_redir_req", 32'(bus.imem_req), 32'd1);
        check("resp_redir_addr", bus.imem_addr, 32'h0000_0100);
        fetch(32'h0000_0100, 32'hB000_0100);

        // Redirect coincident with rvalid
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0104;
        redirect        = 1'b1;
        redirect_pc     = 32'h0000_0200;
        tick();
        bus.imem_rvalid = 1'b0;
        redirect        = 1'b0;
        check("rv_redir_valid", 32'(bus.inst_valid), 32'd0);
        check("rv_redir_addr", bus.imem_addr, 32'h0000_0200);

        // Redirects before grant, last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        check("req_redir_req", 32'(bus.imem_req), 32'd1);
        check("req_redir_addr", bus.imem_addr, 32'h0000_0300);
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        check("req_redir_last", bus.imem_addr, 32'h0000_0400);

        // Decode back-pressure in HOLD, then redirect with inst_ready
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_1234;
        tick();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(bus.inst_valid), 32'd1);
            check("hold_inst", bus.inst, 32'h0000_1234);
            check("hold_pc", bus.inst_pc, 32'h0000_0400);
            check("hold_noreq", 32'(bus.imem_req), 32'd0);
            tick();
        end
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0500;
        bus.inst_ready = 1'b1;
        tick();
        redirect       = 1'b0;
        bus.inst_ready = 1'b0;
        check("hold_rdy_redir_valid", 32'(bus.inst_valid), 32'd0);
        check("hold_rdy_redir_addr", bus.imem_addr, 32'h0000_0500);

        // Redirect in HOLD without inst_ready drops the held word
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0055;
        tick();
        bus.imem_rvalid = 1'b0;
        check("hold2_pc", bus.inst_pc, 32'h0000_0500);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0600;
        tick();
        redirect = 1'b0;
        check("hold_redir_valid", 32'(bus.inst_valid), 32'd0);
        check("hold_redir_addr", bus.imem_addr, 32'h0000_0600);

        // pc wrap-around
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        fetch(32'hFFFF_FFFC, 32'hC000_FFFC);
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Halt from REQ, redirect while halted, resume
        halt_req = 1'b1;
        tick();
        check("halt_req_off", 32'(bus.imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0700;
        tick();
        redirect = 1'b0;
        check("halt_still_off", 32'(bus.imem_req), 32'd0);
        halt_req = 1'b0;
        tick();
        check("resume_req", 32'(bus.imem_req), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h0000_0700);

        // Halt asserted during HOLD: completes handshake then stops
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0777;
        tick();
        bus.imem_rvalid = 1'b0;
        halt_req        = 1'b1;
        bus.inst_ready  = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("halt_hold_req", 32'(bus.imem_req), 32'd0);
        check("halt_hold_valid", 32'(bus.inst_valid), 32'd0);
        halt_req = 1'b0;
        tick();
        check("halt_hold_resume", bus.imem_addr, 32'h0000_0704);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_SEQUENCER_MISALIGN_TRAP_EN
        check("misalign_flag", 32'(misalign), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("misalign_noreq", 32'(bus.imem_req), 32'd0);
            tick();
        end
        check("misalign_sticky", 32'(misalign), 32'd1);
`else
        check("misalign_flag", 32'(misalign), 32'd0);
        check("misalign_req", 32'(bus.imem_req), 32'd1);
        check("misalign_addr", bus.imem_addr, 32'h0000_0100);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        check("midresp_busy", 32'(busy), 32'd1);
`endif

        // Reset mid-transaction; late rvalid must be ignored
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(bus.imem_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(bus.inst_valid), 32'd0);
        check("arst_misalign", 32'(misalign), 32'd0);
        check("arst_inst_pc", bus.inst_pc, 32'h0);
        tick();
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        tick();
        check("late_rv_req", 32'(bus.imem_req), 32'd1);
        check("late_rv_addr", bus.imem_addr, 32'h0000_0000);
        check("late_rv_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        check("late_rv_req2", 32'(bus.imem_req), 32'd1);
        check("late_rv_busy", 32'(busy), 32'd0);
        check("late_rv_valid2", 32'(bus.inst_valid), 32'd0);
        fetch(32'h0000_0000, 32'hE000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, sequential increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  request address.
REQ-007 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 inst_valid  output  1  instruction available to decode stage.
REQ-011 inst  output  32  instruction word.
REQ-012 inst_pc  output  32  address of inst.
REQ-013 inst_ready  input  1  decode consumes inst when inst_valid=1.
REQ-014 redirect  input  1  taken branch/jump (pc_ctr) from branch resolution.
REQ-015 redirect_pc  input  32  target address, sampled when redirect=1.
REQ-016 halt_req  input  1  stop issuing new fetches.
REQ-017 busy  output  1  high whenever a granted request awaits imem_rvalid.
REQ-018 misalign  output  1  misaligned-target trap flag (macro-dependent, REQ-034).

Function
REQ-019 States: IDLE, REQ, RESP, HOLD, HALT; one outstanding request maximum.
REQ-020 IDLE: one cycle after rst_n deassertion, then REQ with pc=RESET_PC.
REQ-021 REQ: imem_req=1, imem_addr=pc; addr SHALL remain stable until imem_gnt; on gnt go RESP, busy=1 next cycle.
REQ-022 RESP: on imem_rvalid, capture imem_rdata/pc into inst/inst_pc, inst_valid=1 next cycle, go HOLD; pc advances by PC_STEP (32-bit wrap-around, 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 HOLD: inst/inst_pc/inst_valid held stable until inst_ready; on inst_ready, go REQ same cycle edge (fetch-to-fetch throughput one instruction per 3 cycles minimum with single-cycle gnt/rvalid).
REQ-024 Redirect in REQ before gnt: pc=redirect_pc next cycle, imem_req stays 1, new address presented; no stability violation because request not yet granted is retracted only on redirect.
REQ-025 Redirect in RESP: set kill flag; arriving rvalid data discarded (inst_valid stays 0); then REQ at redirect_pc.
REQ-026 Redirect in HOLD: inst_valid cleared next cycle, held inst dropped, REQ at redirect_pc.
REQ-027 Redirect coincident with inst_ready in HOLD: redirect wins; next fetch at redirect_pc, not pc+PC_STEP.
REQ-028 Redirect coincident with rvalid in RESP: data discarded, REQ at redirect_pc.
REQ-029 Multiple redirects before refetch: last one wins.
REQ-030 halt_req: completes any outstanding request and HOLD handshake, then enters HALT (imem_req=0); deassertion resumes REQ at current pc; redirect during HALT updates pc.

Reset
REQ-031 Async assertion: state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, busy=0, misalign=0, kill=0, immediately.
REQ-032 Reset mid-transaction: outstanding request abandoned; a late rvalid arriving in IDLE/REQ after reset SHALL be ignored.

Configuration
REQ-033 Macro FETCH_SEQUENCER_MISALIGN_TRAP_EN.
REQ-034 Defined: redirect with redirect_pc[1:0]!=0 sets misalign=1 (sticky until reset), enters HALT, no fetch issued; undefined: misalign tied 0, redirect_pc[1:0] forced to 0.

Verification
REQ-035 Reset release, gnt/rvalid 1-cycle, inst_ready=1 -> fetch addresses 0x0,0x4,0x8; inst_pc matches each.
REQ-036 imem_gnt held low 5 cycles -> imem_addr constant 0x0 throughout, single grant accepted.
REQ-037 redirect=1, redirect_pc=0x100 while in RESP -> rdata for old pc dropped, next imem_addr=0x100.
REQ-038 inst_ready=0 for 4 cycles in HOLD -> inst stable, no imem_req; redirect+inst_ready same cycle -> next addr=redirect_pc.
REQ-039 With macro, redirect_pc=0x102 -> misalign=1, imem_req=0 forever; without macro -> fetch at 0x100.
REQ-040 rst_n pulsed low during RESP, rvalid arrives after release -> ignored, first inst_pc=RESET_PC.
